// File: rtl/i2s_frame_serializer_if.sv
// -----------------------------------------------------------------------------
// i2s_frame_serializer_if
// Stereo frame stream carrying one mixed sample pair per transfer.
// A transfer happens on a clock where s_valid && s_ready are both high.
//
// Signals:
//   s_valid  source -> sink  frame valid
//   s_ready  sink -> source  sink can accept a frame this cycle
//   s_left   source -> sink  left sample, signed two's complement
//   s_right  source -> sink  right sample, signed two's complement
// -----------------------------------------------------------------------------
interface i2s_frame_serializer_if #(
    parameter int DATA_W = 16
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_left;
    logic signed [DATA_W-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );
endinterface

// File: rtl/i2s_frame_serializer.sv
// -----------------------------------------------------------------------------
// i2s_frame_serializer
// Buffers stereo 16-bit frames in a small FIFO and shifts them out as standard
// I2S (MSB first, data delayed one BCLK after each LRCLK edge). BCLK and LRCLK
// are derived from clk by integer division. Each frame boundary pops the FIFO
// head; an empty FIFO at a boundary sends a silent frame and flags an underrun.
//
// Ports:
//   clk             system clock, all logic on posedge
//   rst             synchronous active-high reset
//   enable          1 = run serializer, 0 = hold I2S lines idle
//   s_frame         frame stream input (valid/ready, left/right samples)
//   audio_bclk      I2S bit clock
//   audio_lrclk     I2S word select, 0 = left, 1 = right
//   audio_dout      I2S serial data, changes with BCLK falling
//   frame_tick      one-clk pulse per frame boundary (upstream sample request)
//   underrun        one-clk pulse when a boundary finds the FIFO empty
//   underrun_count  saturating count of underruns
// -----------------------------------------------------------------------------
module i2s_frame_serializer #(
    parameter int BCLK_HALF  = 12,
    parameter int SLOT_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    i2s_frame_serializer_if.slave  s_frame,
    output logic                   audio_bclk,
    output logic                   audio_lrclk,
    output logic                   audio_dout,
    output logic                   frame_tick,
    output logic                   underrun,
    output logic [15:0]            underrun_count
);

    localparam int DATA_W  = 16;
    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * DATA_W;

    // Saturating +1 for the underrun counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Place left/right samples MSB-aligned in their slots, zero padding below.
    function automatic logic [FRAME_W-1:0] frame_word(input logic [ENTRY_W-1:0] entry);
        logic [FRAME_W-1:0] w;
        w = '0;
        w[FRAME_W-1 -: DATA_W]    = entry[ENTRY_W-1:DATA_W];
        w[SLOT_WIDTH-1 -: DATA_W] = entry[DATA_W-1:0];
        return w;
    endfunction

    // Frame FIFO storage (data only, pointers/occupancy are the control state).
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               s_ready_q;

    // Serializer state.
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [15:0]        underrun_cnt_q;

    // Decoded events for this clock.
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               div_tc;
    logic               fall_evt;
    logic               frame_bnd;
    logic [BIT_W-1:0]   bit_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    always_comb begin
        push       = s_frame.s_valid && s_ready_q;
        fifo_empty = (fifo_cnt == '0);
        div_tc     = (div_cnt == DIV_W'(BCLK_HALF - 1));
        // A fall event is the terminal count reached while BCLK is high.
        fall_evt   = enable && div_tc && audio_bclk;
        frame_bnd  = fall_evt && (bit_cnt == BIT_W'(FRAME_W - 1));
        bit_nxt    = frame_bnd ? '0 : bit_cnt + 1'b1;
        pop        = frame_bnd && !fifo_empty;
        cnt_nxt    = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_frame.s_left, s_frame.s_right};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            s_ready_q      <= 1'b0;
            div_cnt        <= '0;
            bit_cnt        <= BIT_W'(FRAME_W - 1);
            shreg          <= '0;
            audio_bclk     <= 1'b0;
            audio_lrclk    <= 1'b0;
            audio_dout     <= 1'b0;
            frame_tick     <= 1'b0;
            underrun       <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= cnt_nxt;
            // Ready reflects occupancy after this cycle's push/pop, so a pop
            // while full only reopens the input on the following cycle.
            s_ready_q <= (cnt_nxt < CNT_W'(FIFO_DEPTH));

            frame_tick <= frame_bnd;
            underrun   <= frame_bnd && fifo_empty;
            if (frame_bnd && fifo_empty) begin
                underrun_cnt_q <= sat_inc(underrun_cnt_q);
            end

            if (!enable) begin
                // Idle lines; restart later from a clean frame boundary.
                div_cnt     <= '0;
                bit_cnt     <= BIT_W'(FRAME_W - 1);
                shreg       <= '0;
                audio_bclk  <= 1'b0;
                audio_lrclk <= 1'b0;
                audio_dout  <= 1'b0;
            end else begin
                div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
                if (div_tc) begin
                    audio_bclk <= ~audio_bclk;
                end
                if (fall_evt) begin
                    bit_cnt     <= bit_nxt;
                    audio_lrclk <= (bit_nxt >= BIT_W'(SLOT_WIDTH));
                    // The MSB leaving at the boundary is the previous frame's
                    // last right bit: this is the one-BCLK I2S data delay.
                    audio_dout  <= shreg[FRAME_W-1];
                    if (frame_bnd) begin
                        shreg <= pop ? frame_word(fifo_mem[rd_ptr]) : '0;
                    end else begin
                        shreg <= {shreg[FRAME_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign s_frame.s_ready = s_ready_q;
    assign underrun_count  = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_i2s_frame_serializer
// Directed bench for i2s_frame_serializer with BCLK_HALF=2, SLOT_WIDTH=16,
// FIFO_DEPTH=4 (BCLK period 4 clks, frame 128 clks). Serial bits are captured
// on BCLK rising edges, MSB first, starting with the bit after a frame_tick:
// {previous R[0], L[15:0], R[15:1]}; LRCLK over the same samples is 0000FFFF.
// -----------------------------------------------------------------------------
module tb_i2s_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        audio_bclk;
    logic        audio_lrclk;
    logic        audio_dout;
    logic        frame_tick;
    logic        underrun;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tick = 0;

    i2s_frame_serializer_if #(.DATA_W(16)) s_if ();

    i2s_frame_serializer #(
        .BCLK_HALF (2),
        .SLOT_WIDTH(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .s_frame       (s_if),
        .audio_bclk    (audio_bclk),
        .audio_lrclk   (audio_lrclk),
        .audio_dout    (audio_dout),
        .frame_tick    (frame_tick),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        bit acc;
        acc = 1'b0;
        s_if.s_left  = l;
        s_if.s_right = r;
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            acc = s_if.s_ready;
            @(negedge clk);
            if (acc) break;
        end
        s_if.s_valid = 1'b0;
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_tick(input string tag, output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic capture(input string tag, input bit do_wait, input logic [31:0] exp_bits,
                           input bit exp_ur, input int exp_period);
        logic [31:0] bits;
        logic [31:0] lr;
        logic        prev;
        int          n;
        int          ticks;
        int          urs;
        bit          got;
        bits = '0; lr = '0; n = 0; ticks = 0; urs = 0;
        if (do_wait) begin
            wait_tick(tag, got);
            if (got) begin
                check({tag, "_ur"}, 32'(underrun), 32'(exp_ur));
                if (exp_period != 0) check({tag, "_period"}, 32'(cyc - last_tick), 32'(exp_period));
                last_tick = cyc;
            end
        end
        prev = audio_bclk;
        for (int i = 0; i < 400 && n < 32; i++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
            if (underrun) urs++;
            if (audio_bclk && !prev) begin
                bits = {bits[30:0], audio_dout};
                lr   = {lr[30:0], audio_lrclk};
                n++;
            end
            prev = audio_bclk;
        end
        check({tag, "_nbits"}, 32'(n), 32'd32);
        check({tag, "_bits"}, bits, exp_bits);
        check({tag, "_lrclk"}, lr, 32'h0000FFFF);
        check({tag, "_extra_tick"}, 32'(ticks), 32'd0);
        check({tag, "_extra_ur"}, 32'(urs), 32'd0);
    endtask

    logic [15:0] bl [5];
    logic [15:0] br [5];
    bit          got;
    int          t0;
    int          falls;
    int          nt;
    logic        pb;

    initial begin
        bl = '{16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hC3A5};
        br = '{16'hFFFE, 16'h0001, 16'h5555, 16'h8000, 16'h0F0F};

        // Reset with valid and enable asserted: nothing may happen.
        rst = 1'b1; enable = 1'b1;
        s_if.s_valid = 1'b1; s_if.s_left = 16'h1111; s_if.s_right = 16'h2222;
        repeat (3) @(negedge clk);
        check("rst_bclk", 32'(audio_bclk), 32'd0);
        check("rst_lrclk", 32'(audio_lrclk), 32'd0);
        check("rst_dout", 32'(audio_dout), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_ur", 32'(underrun), 32'd0);
        check("rst_ucnt", 32'(underrun_count), 32'd0);
        check("rst_ready", 32'(s_if.s_ready), 32'd0);
        rst = 1'b0; enable = 1'b0; s_if.s_valid = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(s_if.s_ready), 32'd1);
        check("rel_ucnt", 32'(underrun_count), 32'd0);

        // Serial format, then two underrun frames.
        push(16'hA5F0, 16'h1234);
        push(16'h8001, 16'h7FFF);
        enable = 1'b1;
        capture("fmt0", 1'b1, {1'b0, 16'hA5F0, 15'h091A}, 1'b0, 0);
        capture("fmt1", 1'b1, {1'b0, 16'h8001, 15'h3FFF}, 1'b0, 128);
        capture("ur0", 1'b1, 32'h80000000, 1'b1, 128);
        check("ur0_cnt", 32'(underrun_count), 32'd1);
        capture("ur1", 1'b1, 32'h00000000, 1'b1, 128);
        check("ur1_cnt", 32'(underrun_count), 32'd2);

        // Saturation of the underrun counter.
        force dut.underrun_cnt_q = 16'hFFFF;
        #1;
        release dut.underrun_cnt_q;
        capture("ursat", 1'b1, 32'h00000000, 1'b1, 128);
        check("ursat_cnt", 32'(underrun_count), 32'hFFFF);

        // Disable while BCLK and LRCLK are high.
        check("dis_pre_lrclk", 32'(audio_lrclk), 32'd1);
        check("dis_pre_bclk", 32'(audio_bclk), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_bclk", 32'(audio_bclk), 32'd0);
        check("dis_lrclk", 32'(audio_lrclk), 32'd0);
        check("dis_dout", 32'(audio_dout), 32'd0);

        // Backpressure: four frames fill the FIFO, fifth is held.
        for (int i = 0; i < 4; i++) push(bl[i], br[i]);
        check("bp_full_ready", 32'(s_if.s_ready), 32'd0);
        s_if.s_left = bl[4]; s_if.s_right = br[4]; s_if.s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_hold_ready", 32'(s_if.s_ready), 32'd0);
        enable = 1'b1;
        wait_tick("bp_pop", got);
        last_tick = cyc;
        check("bp_pop_ready", 32'(s_if.s_ready), 32'd1);
        @(negedge clk);
        s_if.s_valid = 1'b0;
        check("bp_refull_ready", 32'(s_if.s_ready), 32'd0);
        capture("bp0", 1'b0, {1'b0, bl[0], br[0][15:1]}, 1'b0, 0);
        for (int i = 1; i < 5; i++)
            capture($sformatf("bp%0d", i), 1'b1, {br[i-1][0], bl[i], br[i][15:1]}, 1'b0, 128);
        capture("bp_ur", 1'b1, {br[4][0], 31'd0}, 1'b1, 128);

        // Disable mid-frame at bit_cnt=10 while BCLK is high.
        enable = 1'b0;
        @(negedge clk);
        push(16'hFFFF, 16'h0001);
        push(16'h1357, 16'h9BDF);
        push(16'h2468, 16'hACE1);
        enable = 1'b1;
        wait_tick("dm_start", got);
        falls = 0;
        pb = audio_bclk;
        for (int i = 0; i < 200 && falls < 10; i++) begin
            @(negedge clk);
            if (pb && !audio_bclk) falls++;
            pb = audio_bclk;
        end
        for (int i = 0; i < 10 && !audio_bclk; i++) @(negedge clk);
        check("dm_pre_bclk", 32'(audio_bclk), 32'd1);
        check("dm_pre_dout", 32'(audio_dout), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("dm_bclk", 32'(audio_bclk), 32'd0);
        check("dm_lrclk", 32'(audio_lrclk), 32'd0);
        check("dm_dout", 32'(audio_dout), 32'd0);
        nt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_tick || underrun || audio_bclk) nt++;
        end
        check("dm_idle_activity", 32'(nt), 32'd0);
        enable = 1'b1;
        t0 = cyc;
        wait_tick("dm_restart", got);
        check("dm_restart_lat", 32'(cyc - t0), 32'd4);
        check("dm_restart_ur", 32'(underrun), 32'd0);
        last_tick = cyc;
        capture("dm_b", 1'b0, {1'b0, 16'h1357, 15'h4DEF}, 1'b0, 0);
        capture("dm_c", 1'b1, {1'b1, 16'h2468, 15'h5670}, 1'b0, 128);
        capture("dm_ur", 1'b1, 32'h80000000, 1'b1, 128);

        // Reset mid-frame with frames queued: FIFO contents are lost.
        enable = 1'b0;
        @(negedge clk);
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        enable = 1'b1;
        wait_tick("mr_start", got);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mr_bclk", 32'(audio_bclk), 32'd0);
        check("mr_dout", 32'(audio_dout), 32'd0);
        check("mr_ucnt", 32'(underrun_count), 32'd0);
        check("mr_ready", 32'(s_if.s_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_rel_ready", 32'(s_if.s_ready), 32'd1);
        capture("mr_ur", 1'b1, 32'h00000000, 1'b1, 0);
        check("mr_ur_cnt", 32'(underrun_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
